// File: rtl/row_map_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : row_map_pkg
//  Purpose  : Shared constants and state encoding for the row-map loader.
//  Revision : 1.0  initial release
// ============================================================================
package row_map_pkg;

  localparam int ROW_ADDR_W     = 9;
  localparam int ROW_MAP_N_ROWS = 241;

  // Bit offsets of the even and odd entry fields inside a host word
  localparam int DIN_LO_OFS = 0;
  localparam int DIN_HI_OFS = 16;

  // One-hot loader states
  typedef enum logic [6:0] {
    S_IDLE      = 7'(1 << 0),
    S_WAIT_WORD = 7'(1 << 1),
    S_SETUP_LO  = 7'(1 << 2),
    S_WRITE_LO  = 7'(1 << 3),
    S_SETUP_HI  = 7'(1 << 4),
    S_WRITE_HI  = 7'(1 << 5),
    S_DONE      = 7'(1 << 6)
  } state_t;

endpackage : row_map_pkg
`default_nettype wire

// File: rtl/row_map_loader.sv
`default_nettype none
// ============================================================================
//  Module   : row_map_loader
//  Purpose  : Unpacks two row-remap entries per host word and sequences them
//             into the row_map_table write port, one setup cycle ahead of
//             each write strobe. Out-of-range entries are clamped and flagged.
//  Options  : ROW_MAP_IDENTITY_INIT_EN - enables the init pulse, which loads
//             the identity map (entry i = i) without consuming host words.
//  Revision : 1.0  initial release
// ============================================================================
module row_map_loader
  import row_map_pkg::*;
#(
  parameter int ADDR_W = ROW_ADDR_W,
  parameter int N_ROWS = ROW_MAP_N_ROWS,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              init,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [ADDR_W-1:0] mem_write_data,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic [ADDR_W-1:0] entry_count
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N_ROWS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;       // address of the entry being written
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] hi_q, hi_d;         // odd entry parked until its turn
  logic [ADDR_W-1:0] count_q, count_d;
  logic              err_q, err_d;
  logic              load;               // present a new entry next cycle
  logic [ADDR_W-1:0] entry;              // raw entry value being presented

`ifdef ROW_MAP_IDENTITY_INIT_EN
  logic              ident_q, ident_d;   // current load is an identity load
`else
  logic              unused_init;
  assign unused_init = init;
`endif

  // Host word bits outside the two entry fields carry nothing
  logic unused_din;
  assign unused_din = ^{din[WORD_W-1:DIN_HI_OFS+ADDR_W], din[DIN_HI_OFS-1:DIN_LO_OFS+ADDR_W]};

  function automatic logic [ADDR_W-1:0] clamp(input logic [ADDR_W-1:0] e);
    return (e > LAST_ROW) ? LAST_ROW : e;
  endfunction

  // Next-state, counters and write-port presentation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    hi_d    = hi_q;
    count_d = count_q;
    err_d   = err_q;
    load    = 1'b0;
    entry   = '0;
`ifdef ROW_MAP_IDENTITY_INIT_EN
    ident_d = ident_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT_WORD;
          cnt_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
`ifdef ROW_MAP_IDENTITY_INIT_EN
          ident_d = 1'b0;
        end else if (init) begin
          // Identity entries come from the address counter itself
          state_d = S_SETUP_LO;
          cnt_d   = '0;
          count_d = '0;
          err_d   = 1'b0;
          ident_d = 1'b1;
          load    = 1'b1;
          entry   = '0;
`endif
        end
      end
      S_WAIT_WORD: begin
        if (din_valid) begin
          state_d = S_SETUP_LO;
          hi_d    = din[DIN_HI_OFS +: ADDR_W];
          load    = 1'b1;
          entry   = din[DIN_LO_OFS +: ADDR_W];
        end
      end
      S_SETUP_LO: state_d = S_WRITE_LO;
      S_WRITE_LO: begin
        count_d = count_q + 1'b1;
        if (cnt_q == LAST_ROW) begin
          // Table full: the odd half of this word is dropped
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP_HI;
          cnt_d   = cnt_q + 1'b1;
          load    = 1'b1;
          entry   = hi_q;
`ifdef ROW_MAP_IDENTITY_INIT_EN
          if (ident_q) entry = cnt_d;
`endif
        end
      end
      S_SETUP_HI: state_d = S_WRITE_HI;
      S_WRITE_HI: begin
        count_d = count_q + 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_WAIT_WORD;
`ifdef ROW_MAP_IDENTITY_INIT_EN
          if (ident_q) begin
            state_d = S_SETUP_LO;
            load    = 1'b1;
            entry   = cnt_d;
          end
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      addr_d = cnt_d;
      data_d = clamp(entry);
      if (entry > LAST_ROW) err_d = 1'b1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hi_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
`ifdef ROW_MAP_IDENTITY_INIT_EN
      ident_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      err_q   <= err_d;
`ifdef ROW_MAP_IDENTITY_INIT_EN
      ident_q <= ident_d;
`endif
    end
  end

  assign din_ready      = (state_q == S_WAIT_WORD);
  assign we             = (state_q == S_WRITE_LO) || (state_q == S_WRITE_HI);
  assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done           = (state_q == S_DONE);
  assign mem_write_addr = addr_q;
  assign mem_write_data = data_q;
  assign err_range      = err_q;
  assign entry_count    = count_q;

endmodule : row_map_loader
`default_nettype wire

// File: tb/tb_row_map_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_row_map_loader
//  Purpose  : Scoreboard bench for row_map_loader: directed loads push the
//             expected table writes, a monitor pops and compares each strobe.
//  Options  : ROW_MAP_IDENTITY_INIT_EN selects the init-path expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_row_map_loader;

  localparam int AW = 9;
  localparam int NR = 241;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst, start, init, din_valid;
  logic [WW-1:0] din;
  logic          din_ready, we, busy, done, err_range;
  logic [AW-1:0] mem_write_addr, mem_write_data, entry_count;

  row_map_loader #(.ADDR_W(AW), .N_ROWS(NR), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst), .start(start), .init(init),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .we(we), .busy(busy), .done(done), .err_range(err_range),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct packed { logic [AW-1:0] a; logic [AW-1:0] d; } wr_t;
  wr_t exp_q[$];

  int total = 0, bad = 0;
  int we_cnt = 0, acc_cnt = 0, done_cnt = 0, ready_cnt = 0;
  int we_base = 0, last_we_cyc = -100;
  bit spacing_en = 1'b0;
  logic prev_we = 1'b0;
  logic [AW-1:0] prev_a = '0, prev_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every strobe and checks strobe framing
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (din_valid && din_ready) acc_cnt++;
      if (din_ready) ready_cnt++;
      if (we) begin
        chk("we_prev_cycle_low", prev_we, 0);
        chk("addr_held_from_setup", mem_write_addr, prev_a);
        chk("data_held_from_setup", mem_write_data, prev_d);
        chk("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          wr_t e = exp_q.pop_front();
          chk("wr_addr", mem_write_addr, e.a);
          chk("wr_data", mem_write_data, e.d);
        end
        if (spacing_en && (we_cnt - we_base) > 0)
          chk("we_spacing", cyc - last_we_cyc, ((we_cnt - we_base) % 2 == 1) ? 2 : 3);
        we_cnt++;
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_we", cyc - last_we_cyc, 1);
        chk("busy_low_at_done", busy, 0);
      end
      prev_we = we;
      prev_a  = mem_write_addr;
      prev_d  = mem_write_data;
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_addr", mem_write_addr, 0);
    chk("rst_data", mem_write_data, 0);
    chk("rst_we", we, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_range", err_range, 0);
    chk("rst_entry_count", entry_count, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one word after `gap` idle cycles and hold it until accepted
  task automatic send_word(input logic [WW-1:0] w, input int gap);
    bit ok = 1'b0;
    if (gap > 0) begin
      din_valid = 1'b0;
      repeat (gap) tick();
    end
    din       = w;
    din_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (din_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    chk("word_accepted", ok, 1);
  endtask

  task automatic wait_done(input int bound);
    int d0 = done_cnt;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt != d0) break;
      tick();
    end
    repeat (3) tick();
    chk("done_pulse_count", done_cnt - d0, 1);
  endtask

  function automatic logic [WW-1:0] mk_word(input int lo, input int hi);
    return (WW'(hi) << 16) | WW'(lo);
  endfunction

  initial begin
    int wb, ab, db, rb;
    fork
      monitor();
    join_none

    rst = 1'b1; start = 1'b0; init = 1'b0; din_valid = 1'b0; din = '0;
    repeat (3) tick();
    check_reset_outputs();
    rst = 1'b0;
    tick();

    // Full load: word k = {2k+2, 2k+1}; last even entry 241 clamps to 240
    for (int i = 0; i < NR; i++) exp_q.push_back({AW'(i), AW'((i + 1 > NR - 1) ? NR - 1 : i + 1)});
    wb = we_cnt; ab = acc_cnt;
    we_base = we_cnt; spacing_en = 1'b1;
    pulse_start();
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < 121; k++) send_word(mk_word(2 * k + 1, 2 * k + 2), 0);
    din_valid = 1'b0;
    wait_done(50);
    spacing_en = 1'b0;
    chk("full_we_count", we_cnt - wb, 241);
    chk("full_words", acc_cnt - ab, 121);
    chk("full_err_range", err_range, 1);
    chk("full_entry_count", entry_count, 241);
    chk("full_busy_after", busy, 0);
    chk("full_scoreboard_empty", exp_q.size(), 0);

    // Backpressure: 3 idle cycles before each word, identity entries
    for (int i = 0; i < NR; i++) exp_q.push_back({AW'(i), AW'(i)});
    wb = we_cnt; ab = acc_cnt;
    pulse_start();
    chk("bp_err_cleared", err_range, 0);
    for (int k = 0; k < 121; k++) send_word(mk_word(2 * k, 2 * k + 1), 3);
    din_valid = 1'b0;
    wait_done(50);
    chk("bp_we_count", we_cnt - wb, 241);
    chk("bp_words", acc_cnt - ab, 121);
    chk("bp_err_range", err_range, 0);
    chk("bp_entry_count", entry_count, 241);
    chk("bp_scoreboard_empty", exp_q.size(), 0);

    // Control edges: start while busy is ignored, rst aborts at entry 50
    for (int i = 0; i < 50; i++) exp_q.push_back({AW'(i), AW'(i + 1)});
    wb = we_cnt; ab = acc_cnt; db = done_cnt;
    pulse_start();
    for (int k = 0; k <= 25; k++) begin
      send_word(mk_word(2 * k + 1, 2 * k + 2), 0);
      if (k == 5) pulse_start();
    end
    rst = 1'b1; din_valid = 1'b0;
    tick();
    check_reset_outputs();
    rst = 1'b0;
    repeat (4) tick();
    chk("abort_we_count", we_cnt - wb, 50);
    chk("abort_words", acc_cnt - ab, 26);
    chk("abort_no_done", done_cnt - db, 0);
    chk("abort_scoreboard_empty", exp_q.size(), 0);

    // New start after abort restarts at address 0
    for (int i = 0; i < 6; i++) exp_q.push_back({AW'(i), AW'(i + 7)});
    pulse_start();
    for (int k = 0; k < 3; k++) send_word(mk_word(2 * k + 7, 2 * k + 8), 0);
    din_valid = 1'b0;
    repeat (6) tick();
    chk("restart_scoreboard_empty", exp_q.size(), 0);
    chk("restart_entry_count", entry_count, 6);
    chk("restart_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Identity init path
    wb = we_cnt; db = done_cnt; rb = ready_cnt;
`ifdef ROW_MAP_IDENTITY_INIT_EN
    for (int i = 0; i < NR; i++) exp_q.push_back({AW'(i), AW'(i)});
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_busy", busy, 1);
    wait_done(600);
    chk("init_we_count", we_cnt - wb, 241);
    chk("init_ready_never", ready_cnt - rb, 0);
    chk("init_err_range", err_range, 0);
    chk("init_entry_count", entry_count, 241);
    chk("init_scoreboard_empty", exp_q.size(), 0);
`else
    init = 1'b1;
    tick();
    init = 1'b0;
    chk("init_ignored_busy", busy, 0);
    repeat (20) tick();
    chk("init_ignored_we", we_cnt - wb, 0);
    chk("init_ignored_done", done_cnt - db, 0);
    chk("init_ignored_ready", ready_cnt - rb, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_row_map_loader
`default_nettype wire
